regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-port arbiter and sequencer for the 4-writable/3-constant 8-bit register file. It shares the register file's single select/load port between requester A (core datapath) and requester B (debug/loader) using round-robin arbitration. It converts each request into a correctly timed write or read cycle on the register file and returns an ack, a write-protect error flag and read data. It sits between the requesters and the register file and is the only driver of the register file's load/select/data inputs.

## Interface
- WRITABLE_REGS, 4, register addresses 0..WRITABLE_REGS-1 accept writes; all others are write-protected
- RST_PRIO, 0, requester that wins the first tie after reset (0 = A, 1 = B)

- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_aReq / i_bReq  in  1  request; held high until the matching ack
- i_aWe / i_bWe  in  1  1 = write, 0 = read
- i_aSel / i_bSel  in  4  register address
- i_aData / i_bData  in  8  write data
- o_aAck / o_bAck  out  1  one-cycle completion pulse
- o_aErr / o_bErr  out  1  valid with ack; 1 = write to protected address was discarded
- o_aData / o_bData  out  8  read data; valid with ack, held until that port's next read completes
- o_rfLd  out  1  to register file load signal
- o_rfSel  out  4  to register file select
- o_rfData  out  8  to register file data in
- i_rfData  in  8  from register file data out (registered in the register file, 1-cycle read latency)
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE. All outputs are registered.
- **IDLE**
  - Samples the requests.
  - If neither request is high, stays in IDLE.
  - If exactly one is high, that requester is granted.
  - If both are high, the requester named by the priority bit is granted.
  - On a grant: latch the granted requester's We/Sel/Data and its port id, flip the priority bit to the other requester, and go to ISSUE.
- **ISSUE**
  - o_rfSel = latched Sel.
  - o_rfData = latched Data.
  - o_rfLd = We AND (Sel < WRITABLE_REGS).
  - Always goes to CAPTURE.
- **CAPTURE**
  - o_rfLd = 0 and o_rfSel is held, so the register file presents the addressed value.
  - On exit, latch i_rfData into the granted port's data register, but only if the operation is a read.
  - Set the granted port's Ack.
  - Set its Err = We AND (Sel >= WRITABLE_REGS).
  - Go to DONE.
- **DONE**
  - Ack/Err high for exactly this cycle; requests are ignored.
  - Always goes to IDLE, where Ack and Err return to 0.
- Reads of the constant/unused addresses (8 = 0x00, 9 = 0x01, 10 = 0xFF, others = 0x00) pass through unmodified, with Err = 0.
- The ungranted requester's outputs do not change during another port's transaction.
- The priority bit flips only on a grant, never on idle cycles.

## Timing
- A request sampled in IDLE at cycle c0 produces ISSUE at c1, CAPTURE at c2, and Ack at c3. Throughput is one transaction per 4 cycles.
- A requester must deassert req no later than c4 (the IDLE cycle after ack). A req still high at c4 starts a new transaction.
- The register file performs the write on the rising edge ending ISSUE. o_rfLd is high for exactly one cycle per legal write and is never high for reads or protected writes.
- Changes on the request inputs during ISSUE/CAPTURE/DONE have no effect; the latched copy is used.
- Reset values:
  - State = IDLE.
  - o_rfLd, o_rfSel, o_rfData = 0.
  - o_aAck, o_bAck, o_aErr, o_bErr = 0.
  - o_aData, o_bData = 0x00.
  - o_busy = 0.
  - Priority = RST_PRIO.
- Reset mid-transaction: immediate return to IDLE with o_rfLd = 0 and no ack. A write is lost if reset arrives before the ISSUE edge. Register file contents are not reset by this block.

## Test plan
- Reset, then A writes 0x5A to reg 2 (req at c0): o_rfLd = 1, o_rfSel = 2, o_rfData = 0x5A in c1 only; o_aAck = 1, o_aErr = 0 at c3; o_busy falls at c4.
- A reads reg 2 after the above: o_aAck at c3 with o_aData = 0x5A; A reads reg 10: o_aData = 0xFF; A reads reg 9: o_aData = 0x01.
- B writes 0x33 to reg 9: o_rfLd stays 0 throughout, o_bAck = 1 and o_bErr = 1 at c3; a following read of reg 9 returns 0x01.
- A and B both request continuously from reset (RST_PRIO = 0): grants alternate A, B, A, B with acks every 4 cycles; o_aData/o_bData each update only on their own read acks.
- Assert i_rst during ISSUE of a write: no ack, o_rfLd = 0 immediately, state IDLE; after release, with both requesting, A is granted first.
- Requester changes i_aSel from 1 to 3 during CAPTURE: the transaction completes on reg 1, and the change is ignored.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Request/response and register-file port bundle for regfile_arbiter.
// slave = arbiter side, master = requester side, regfile = register file side.
interface regfile_arbiter_if;
  logic       i_aReq;
  logic       i_bReq;
  logic       i_aWe;
  logic       i_bWe;
  logic [3:0] i_aSel;
  logic [3:0] i_bSel;
  logic [7:0] i_aData;
  logic [7:0] i_bData;
  logic       o_aAck;
  logic       o_bAck;
  logic       o_aErr;
  logic       o_bErr;
  logic [7:0] o_aData;
  logic [7:0] o_bData;
  logic       o_rfLd;
  logic [3:0] o_rfSel;
  logic [7:0] o_rfData;
  logic [7:0] i_rfData;
  logic       o_busy;

  modport slave (
    input  i_aReq, i_bReq, i_aWe, i_bWe, i_aSel, i_bSel, i_aData, i_bData, i_rfData,
    output o_aAck, o_bAck, o_aErr, o_bErr, o_aData, o_bData,
           o_rfLd, o_rfSel, o_rfData, o_busy
  );

  modport master (
    output i_aReq, i_bReq, i_aWe, i_bWe, i_aSel, i_bSel, i_aData, i_bData,
    input  o_aAck, o_bAck, o_aErr, o_bErr, o_aData, o_bData, o_busy
  );

  modport regfile (
    input  o_rfLd, o_rfSel, o_rfData,
    output i_rfData
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-file select/load port
// between requester A and requester B; all outputs registered.
module regfile_arbiter #(
  parameter int unsigned WRITABLE_REGS = 4,
  parameter bit          RST_PRIO      = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  regfile_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic [4:0] WR_LIMIT = 5'(WRITABLE_REGS);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       port_q, port_d;
  logic       we_q, we_d;
  logic       rfLd_q, rfLd_d;
  logic [3:0] rfSel_q, rfSel_d;
  logic [7:0] rfData_q, rfData_d;
  logic       aAck_q, aAck_d, bAck_q, bAck_d;
  logic       aErr_q, aErr_d, bErr_q, bErr_d;
  logic [7:0] aData_q, aData_d, bData_q, bData_d;
  logic       busy_q, busy_d;

  logic       grant;
  logic       req_we;
  logic [3:0] req_sel;
  logic [7:0] req_data;
  logic       prot_err;

  function automatic logic writable(input logic [3:0] sel);
    return {1'b0, sel} < WR_LIMIT;
  endfunction

  // grant = 1 selects B: B alone, or both requesting with priority on B
  assign grant    = bus.i_bReq & (~bus.i_aReq | prio_q);
  assign req_we   = grant ? bus.i_bWe   : bus.i_aWe;
  assign req_sel  = grant ? bus.i_bSel  : bus.i_aSel;
  assign req_data = grant ? bus.i_bData : bus.i_aData;
  // rfSel_q holds the latched address for the whole transaction
  assign prot_err = we_q & ~writable(rfSel_q);

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    port_d   = port_q;
    we_d     = we_q;
    rfLd_d   = 1'b0;
    rfSel_d  = rfSel_q;
    rfData_d = rfData_q;
    aAck_d   = 1'b0;
    bAck_d   = 1'b0;
    aErr_d   = 1'b0;
    bErr_d   = 1'b0;
    aData_d  = aData_q;
    bData_d  = bData_q;
    case (state_q)
      IDLE: begin
        if (bus.i_aReq | bus.i_bReq) begin
          port_d   = grant;
          prio_d   = ~grant;
          we_d     = req_we;
          rfSel_d  = req_sel;
          rfData_d = req_data;
          rfLd_d   = req_we & writable(req_sel);
          state_d  = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        if (port_q) begin
          bAck_d = 1'b1;
          bErr_d = prot_err;
          if (!we_q) bData_d = bus.i_rfData;
        end else begin
          aAck_d = 1'b1;
          aErr_d = prot_err;
          if (!we_q) aData_d = bus.i_rfData;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      prio_q   <= RST_PRIO;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      rfLd_q   <= 1'b0;
      rfSel_q  <= '0;
      rfData_q <= '0;
      aAck_q   <= 1'b0;
      bAck_q   <= 1'b0;
      aErr_q   <= 1'b0;
      bErr_q   <= 1'b0;
      aData_q  <= '0;
      bData_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      port_q   <= port_d;
      we_q     <= we_d;
      rfLd_q   <= rfLd_d;
      rfSel_q  <= rfSel_d;
      rfData_q <= rfData_d;
      aAck_q   <= aAck_d;
      bAck_q   <= bAck_d;
      aErr_q   <= aErr_d;
      bErr_q   <= bErr_d;
      aData_q  <= aData_d;
      bData_q  <= bData_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_rfLd   = rfLd_q;
  assign bus.o_rfSel  = rfSel_q;
  assign bus.o_rfData = rfData_q;
  assign bus.o_aAck   = aAck_q;
  assign bus.o_bAck   = bAck_q;
  assign bus.o_aErr   = aErr_q;
  assign bus.o_bErr   = bErr_q;
  assign bus.o_aData  = aData_q;
  assign bus.o_bData  = bData_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register file
// (4 writable regs, constants at 8/9/10, 1-cycle registered read).
module tb_regfile_arbiter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  regfile_arbiter_if bus();

  regfile_arbiter #(
    .WRITABLE_REGS(4),
    .RST_PRIO(1'b0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  // Register file environment
  logic [7:0] rf_mem [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  always @(posedge i_clk) begin
    if (bus.o_rfLd && bus.o_rfSel < 4'd4) rf_mem[bus.o_rfSel[1:0]] <= bus.o_rfData;
    case (bus.o_rfSel)
      4'd0, 4'd1, 4'd2, 4'd3: bus.i_rfData <= rf_mem[bus.o_rfSel[1:0]];
      4'd9:                   bus.i_rfData <= 8'h01;
      4'd10:                  bus.i_rfData <= 8'hFF;
      default:                bus.i_rfData <= 8'h00;
    endcase
  end

  // Scoreboard state
  logic [7:0] model_mem [0:3];
  logic [7:0] exp_aData, exp_bData;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [7:0] model_read(input logic [3:0] s);
    if (s < 4'd4)  return model_mem[s[1:0]];
    if (s == 4'd9) return 8'h01;
    if (s == 4'd10) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit port, input bit req, input bit we,
                         input logic [3:0] sel, input logic [7:0] d);
    if (port) begin
      bus.i_bReq = req; bus.i_bWe = we; bus.i_bSel = sel; bus.i_bData = d;
    end else begin
      bus.i_aReq = req; bus.i_aWe = we; bus.i_aSel = sel; bus.i_aData = d;
    end
  endtask

  // One isolated transaction, starting at a negedge in IDLE, ending at c4 negedge
  task automatic do_txn(input bit port, input bit we, input logic [3:0] sel,
                        input logic [7:0] wd, input logic [3:0] gsel,
                        input bit e_ld, input bit e_err, input logic [7:0] e_rd);
    logic [7:0] own_exp, oth_exp;
    set_req(port, 1'b1, we, sel, wd);
    @(negedge i_clk);  // c1: ISSUE
    chk("c1_rfLd",   32'(bus.o_rfLd), 32'(e_ld));
    chk("c1_rfSel",  32'(bus.o_rfSel), 32'(sel));
    chk("c1_rfData", 32'(bus.o_rfData), 32'(wd));
    chk("c1_busy",   32'(bus.o_busy), 32'd1);
    @(negedge i_clk);  // c2: CAPTURE
    chk("c2_rfLd",  32'(bus.o_rfLd), 32'd0);
    chk("c2_rfSel", 32'(bus.o_rfSel), 32'(sel));
    set_req(port, 1'b1, we, gsel, ~wd);
    @(negedge i_clk);  // c3: DONE
    if (!we) begin
      if (port) exp_bData = e_rd; else exp_aData = e_rd;
    end
    if (we && !e_err) model_mem[sel[1:0]] = wd;
    own_exp = port ? exp_bData : exp_aData;
    oth_exp = port ? exp_aData : exp_bData;
    chk("c3_ack",     32'(port ? bus.o_bAck : bus.o_aAck), 32'd1);
    chk("c3_othAck",  32'(port ? bus.o_aAck : bus.o_bAck), 32'd0);
    chk("c3_err",     32'(port ? bus.o_bErr : bus.o_aErr), 32'(e_err));
    chk("c3_othErr",  32'(port ? bus.o_aErr : bus.o_bErr), 32'd0);
    chk("c3_data",    32'(port ? bus.o_bData : bus.o_aData), 32'(own_exp));
    chk("c3_othData", 32'(port ? bus.o_aData : bus.o_bData), 32'(oth_exp));
    chk("c3_rfLd",    32'(bus.o_rfLd), 32'd0);
    set_req(port, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge i_clk);  // c4: IDLE
    chk("c4_ack",  32'(port ? bus.o_bAck : bus.o_aAck), 32'd0);
    chk("c4_busy", 32'(bus.o_busy), 32'd0);
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] sel;
    logic [7:0] wd;
    logic [3:0] gsel;
    bit         e_ld;
    bit         e_err;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
    exp_aData = 8'h00;
    exp_bData = 8'h00;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // port, we, sel, wdata, sel-after-capture, exp ld, exp err, exp read data
    vecs[0]  = '{1'b0, 1'b1, 4'd2,  8'h5A, 4'd7, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'd2,  8'h00, 4'd6, 1'b0, 1'b0, 8'h5A};
    vecs[2]  = '{1'b0, 1'b0, 4'd10, 8'h00, 4'd2, 1'b0, 1'b0, 8'hFF};
    vecs[3]  = '{1'b0, 1'b0, 4'd9,  8'h00, 4'd2, 1'b0, 1'b0, 8'h01};
    vecs[4]  = '{1'b1, 1'b1, 4'd9,  8'h33, 4'd2, 1'b0, 1'b1, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 4'd9,  8'h00, 4'd2, 1'b0, 1'b0, 8'h01};
    vecs[6]  = '{1'b0, 1'b1, 4'd3,  8'hC3, 4'd0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 4'd3,  8'h00, 4'd2, 1'b0, 1'b0, 8'hC3};
    vecs[8]  = '{1'b1, 1'b1, 4'd15, 8'h77, 4'd1, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 4'd15, 8'h00, 4'd3, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 4'd0,  8'h11, 4'd2, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  8'h00, 4'd3, 1'b0, 1'b0, 8'h11};
    vecs[12] = '{1'b1, 1'b0, 4'd8,  8'h00, 4'd2, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 4'd4,  8'hAA, 4'd3, 1'b0, 1'b1, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 4'd4,  8'h00, 4'd0, 1'b0, 1'b0, 8'h00};
    vecs[15] = '{1'b1, 1'b0, 4'd1,  8'h00, 4'd3, 1'b0, 1'b0, 8'h42};

    // Reset state, with both requesters already asking (A reads 10, B writes reg 1)
    set_req(1'b0, 1'b1, 1'b0, 4'd10, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 4'd1,  8'h42);
    repeat (3) @(negedge i_clk);
    chk("rst_rfLd",   32'(bus.o_rfLd), 32'd0);
    chk("rst_rfSel",  32'(bus.o_rfSel), 32'd0);
    chk("rst_rfData", 32'(bus.o_rfData), 32'd0);
    chk("rst_aAck",   32'(bus.o_aAck), 32'd0);
    chk("rst_bAck",   32'(bus.o_bAck), 32'd0);
    chk("rst_aErr",   32'(bus.o_aErr), 32'd0);
    chk("rst_bErr",   32'(bus.o_bErr), 32'd0);
    chk("rst_aData",  32'(bus.o_aData), 32'd0);
    chk("rst_bData",  32'(bus.o_bData), 32'd0);
    chk("rst_busy",   32'(bus.o_busy), 32'd0);
    i_rst = 1'b0;

    // Continuous contention: grants A, B, A, B with one ack per 4 cycles
    for (int j = 1; j <= 16; j++) begin
      @(negedge i_clk);
      chk("rr_aAck",  32'(bus.o_aAck), 32'((j == 3) || (j == 11)));
      chk("rr_bAck",  32'(bus.o_bAck), 32'((j == 7) || (j == 15)));
      chk("rr_rfLd",  32'(bus.o_rfLd), 32'((j == 5) || (j == 13)));
      chk("rr_aData", 32'(bus.o_aData), (j >= 3) ? 32'hFF : 32'h00);
      chk("rr_bData", 32'(bus.o_bData), 32'h00);
      chk("rr_bErr",  32'(bus.o_bErr), 32'd0);
      if (j == 15) begin
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      end
    end
    chk("rr_idle_busy", 32'(bus.o_busy), 32'd0);
    model_mem[1] = 8'h42;
    exp_aData = 8'hFF;

    for (int i = 0; i < 16; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].gsel,
             vecs[i].e_ld, vecs[i].e_err, vecs[i].e_rd);

    // Address change 1 -> 3 during CAPTURE must not affect the read of reg 1
    do_txn(1'b0, 1'b0, 4'd1, 8'h00, 4'd3, 1'b0, 1'b0, model_read(4'd1));

    // Randomized single-requester traffic against the scoreboard
    for (int i = 0; i < 40; i++) begin
      bit         p, w;
      logic [3:0] s, g;
      logic [7:0] d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      g = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      do_txn(p, w, s, d, g, w && (s < 4'd4), w && (s >= 4'd4), model_read(s));
    end

    // Reset during ISSUE of a legal write: write lost, no ack, priority back to A
    set_req(1'b0, 1'b1, 1'b1, 4'd3, 8'h99);
    @(negedge i_clk);
    chk("ri_issue_rfLd", 32'(bus.o_rfLd), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("ri_rfLd",  32'(bus.o_rfLd), 32'd0);
    chk("ri_busy",  32'(bus.o_busy), 32'd0);
    chk("ri_aAck",  32'(bus.o_aAck), 32'd0);
    chk("ri_aData", 32'(bus.o_aData), 32'd0);
    exp_aData = 8'h00;
    exp_bData = 8'h00;
    set_req(1'b0, 1'b1, 1'b0, 4'd3,  8'h00);
    set_req(1'b1, 1'b1, 1'b0, 4'd10, 8'h00);
    repeat (2) @(negedge i_clk);
    chk("ri_held_aAck", 32'(bus.o_aAck), 32'd0);
    i_rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge i_clk);
      chk("ri_aAck", 32'(bus.o_aAck), 32'(j == 3));
      chk("ri_bAck", 32'(bus.o_bAck), 32'(j == 7));
      if (j == 3) begin
        chk("ri_aData_after", 32'(bus.o_aData), 32'(model_mem[3]));
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      end
      if (j == 7) begin
        chk("ri_bData_after", 32'(bus.o_bData), 32'hFF);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
      end
    end
    chk("end_busy", 32'(bus.o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
